// File: rtl/verinject_pkg.sv
// verinject_pkg: reserved injector bus commands and scheduler FSM encoding shared across the harness
package verinject_pkg;
  localparam logic [31:0] IDLE_CMD       = 32'hFFFF_FFFF;
  localparam logic [31:0] FIFO_RESET_CMD = 32'hFFFF_FFFE;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_CLEAR} state_t;
endpackage

// File: rtl/verinject_injection_scheduler_if.sv
// verinject_injection_scheduler_if: host schedule-entry handshake (valid/ready plus cycle and injector index)
interface verinject_injection_scheduler_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_cycle;
  logic [31:0] cfg_index;
  modport master (output cfg_valid, cfg_cycle, cfg_index, input cfg_ready);
  modport slave (input cfg_valid, cfg_cycle, cfg_index, output cfg_ready);
endinterface

// File: rtl/verinject_schedule_table.sv
// verinject_schedule_table: DEPTH-entry (cycle,index) store with append pointer, monotonic-cycle/reserved-index checks, sticky error; ports: wr_en/wr_cycle/wr_index append, flush empties, rd_ptr selects rd_cycle/rd_index, count/full/error status
module verinject_schedule_table
  import verinject_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  flush,
  input  logic [31:0]           wr_cycle,
  input  logic [31:0]           wr_index,
  input  logic [DEPTH_LOG2-1:0] rd_ptr,
  output logic [31:0]           rd_cycle,
  output logic [31:0]           rd_index,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  error
);
  logic [31:0] cyc_mem [DEPTH];
  logic [31:0] idx_mem [DEPTH];
  logic [31:0] last_cycle;
  logic        reject;
  // Reserved bus values can never be scheduled; cycles must strictly increase so at most one issue per cycle.
  assign reject   = wr_index >= FIFO_RESET_CMD || (count != '0 && wr_cycle <= last_cycle);
  assign full     = count == (DEPTH_LOG2+1)'(DEPTH);
  assign rd_cycle = cyc_mem[rd_ptr];
  assign rd_index = idx_mem[rd_ptr];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= '0;
      error      <= 1'b0;
      last_cycle <= '0;
    end else if (flush) begin
      count <= '0;
      error <= 1'b0;
    end else if (wr_en) begin
      if (reject) error <= 1'b1;
      else begin
        count      <= count + 1'b1;
        last_cycle <= wr_cycle;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (wr_en && !flush && !reject) begin
      cyc_mem[count[DEPTH_LOG2-1:0]] <= wr_cycle;
      idx_mem[count[DEPTH_LOG2-1:0]] <= wr_index;
    end
  end
endmodule

// File: rtl/verinject_injection_scheduler.sv
// verinject_injection_scheduler: replays a loaded (cycle,index) table onto the injector bus, one cycle per entry; ports: clock/reset, cfg entry handshake, cfg_flush/start/abort/clear_req controls, verinject__injector_state bus, busy/done/cfg_error/entry_count/issued_count status
module verinject_injection_scheduler
  import verinject_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  verinject_injection_scheduler_if.slave cfg,
  input  logic                    cfg_flush,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    clear_req,
  output logic [31:0]             verinject__injector_state,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_error,
  output logic [DEPTH_LOG2:0]     entry_count,
  output logic [DEPTH_LOG2:0]     issued_count
);
  state_t                state, state_n;
  logic [31:0]           bus_n, run_cnt, rd_cycle, rd_index;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic                  full, load, flush, launch, issue, finish;
  verinject_schedule_table #(.DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2)) u_table (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (load),
    .flush    (flush),
    .wr_cycle (cfg.cfg_cycle),
    .wr_index (cfg.cfg_index),
    .rd_ptr   (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_cycle (rd_cycle),
    .rd_index (rd_index),
    .count    (entry_count),
    .full     (full),
    .error    (cfg_error)
  );
  assign cfg.cfg_ready = state == ST_IDLE && !full;
  assign busy          = state != ST_IDLE;
  // IDLE arbitration: flush > clear > start > load; losers are dropped.
  always_comb begin
    state_n = state;
    bus_n   = IDLE_CMD;
    load    = 1'b0;
    flush   = 1'b0;
    launch  = 1'b0;
    issue   = 1'b0;
    finish  = 1'b0;
    case (state)
      ST_IDLE:
        if (cfg_flush) flush = 1'b1;
        else if (clear_req) begin
          state_n = ST_CLEAR;
          bus_n   = FIFO_RESET_CMD;
        end else if (start) begin
          launch  = 1'b1;
          state_n = entry_count == '0 ? ST_IDLE : ST_RUN;
        end else load = cfg.cfg_valid && cfg.cfg_ready;
      // run_cnt equals C during the cycle before entry C is driven, so the registered bus shows it C+1 edges after start.
      ST_RUN:
        if (abort) state_n = ST_IDLE;
        else if (rd_ptr == entry_count) begin
          state_n = ST_IDLE;
          finish  = 1'b1;
        end else if (run_cnt == rd_cycle) begin
          bus_n = rd_index;
          issue = 1'b1;
        end
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                     <= ST_IDLE;
      verinject__injector_state <= IDLE_CMD;
      run_cnt                   <= '0;
      rd_ptr                    <= '0;
      issued_count              <= '0;
      done                      <= 1'b0;
    end else begin
      state                     <= state_n;
      verinject__injector_state <= bus_n;
      run_cnt                   <= launch ? '0 : run_cnt + 32'(state == ST_RUN);
      rd_ptr                    <= launch ? '0 : rd_ptr + (DEPTH_LOG2+1)'(issue);
      issued_count              <= launch ? '0 : issued_count + (DEPTH_LOG2+1)'(issue);
      done                      <= launch ? entry_count == '0 : done | finish;
    end
  end
endmodule

// File: doc/verinject_injection_scheduler.md
Name: verinject_injection_scheduler

Overview:
- Time-based sequencer that drives the 32-bit `verinject__injector_state` bus consumed by all fault injectors.
- A host loads a small table of (cycle, bit-index) entries; on `start` the block replays each index for exactly one clock at its scheduled cycle.
- It also issues the one-cycle FIFO-reset command on request.
- Sits at the top of the fault-injection harness, between the testbench/host and the injector instances.

Parameters:
- DEPTH, 8, number of schedule entries (power of two, >= 2).
- DEPTH_LOG2, 3, log2(DEPTH); pointer width is DEPTH_LOG2+1.

Ports:
- clock  input  1  sole clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- cfg_valid  input  1  host offers a schedule entry.
- cfg_ready  output  1  entry accepted on the cycle where cfg_valid&cfg_ready.
- cfg_cycle  input  32  run-relative cycle at which the entry is issued.
- cfg_index  input  32  injector index to drive.
- cfg_flush  input  1  empties the table (IDLE only).
- start  input  1  begins a run (IDLE only).
- abort  input  1  terminates a run.
- clear_req  input  1  requests the injector FIFO-reset command (IDLE only).
- verinject__injector_state  output  32  registered injector command bus.
- busy  output  1  high in RUN and CLEAR.
- done  output  1  sticky; set when a run completes normally.
- cfg_error  output  1  sticky; set by a rejected entry.
- entry_count  output  DEPTH_LOG2+1  entries currently stored.
- issued_count  output  DEPTH_LOG2+1  entries issued in the current/last run.

Behaviour:
- Reserved bus values: IDLE_CMD=32'hFFFF_FFFF (no injection), FIFO_RESET_CMD=32'hFFFF_FFFE.
- Reset values: bus=IDLE_CMD; FSM=IDLE; table empty; busy, done, cfg_error, entry_count, issued_count, run counter all 0. Reset mid-run returns the bus to IDLE_CMD asynchronously.
- FSM states: IDLE, RUN, CLEAR.
- IDLE, table loading:
  - cfg_ready = (entry_count < DEPTH).
  - An accepted entry is stored at entry_count, which then increments.
  - Rejections: an entry is rejected if cfg_index >= 32'hFFFF_FFFE, or if entry_count>0 and cfg_cycle <= last stored cycle (cycles must be strictly increasing).
  - A rejected entry is still consumed (ready high), is not stored, and sets cfg_error.
  - cfg_ready=0 outside IDLE.
- IDLE priority when several requests arrive together: cfg_flush > clear_req > start > cfg load.
  - The losing requests are dropped, not queued.
  - cfg_flush zeroes entry_count and clears cfg_error.
- clear_req: IDLE->CLEAR. The bus is FIFO_RESET_CMD for exactly one cycle, then IDLE_CMD and IDLE.
- start in IDLE:
  - Clears done and issued_count; zeroes the run counter; sets rd_ptr=0.
  - If entry_count==0: stay in IDLE and set done next cycle.
  - Otherwise go to RUN.
- RUN:
  - The run counter increments every cycle.
  - Entry k (cycle C, index I) drives bus=I during exactly the single cycle beginning C+1 edges after the edge that sampled start. Example: C=0 gives I on the first cycle after start.
  - Every other RUN cycle the bus is IDLE_CMD.
  - After an issue, rd_ptr and issued_count increment.
  - After the last entry is issued, the FSM returns to IDLE next cycle with done=1; the table is retained, so re-start replays it.
- abort in RUN: abort beats a same-cycle issue. Next cycle: bus=IDLE_CMD, IDLE, done stays 0.
- start, clear_req and cfg_flush are ignored in RUN and CLEAR.
- Run counter: 32-bit, no wrap handling required (a schedule cannot exceed 2^32-2).

Decomposition:
- Shared package/header verinject_pkg:
  - IDLE_CMD and FIFO_RESET_CMD constants (reuse in the injectors);
  - FSM state encoding.
- Sub-module verinject_schedule_table: DEPTH-entry storage, write pointer, monotonic/reserved-value checks and error flag. It exposes the entry at rd_ptr.

Test Plan:
- Load (0,5),(3,17),(4,40); pulse start at edge E → bus=5 at E+1, 17 at E+4, 40 at E+5, 0xFFFFFFFF elsewhere; done=1 at E+6; issued_count=3.
- Load (2,7),(2,9) → second entry consumed, cfg_error=1, entry_count=1; cfg_index=0xFFFF_FFFE also rejected.
- clear_req in IDLE → bus=0xFFFF_FFFE for exactly one cycle, busy high that cycle; clear_req with start in the same cycle → clear only, no run.
- Load (10,3); start, abort at run cycle 5 → bus never 3, done=0, FSM IDLE; re-start replays (10,3).
- Fill DEPTH=8 entries → cfg_ready=0 on the 9th offer; start with empty table → done=1 next cycle, bus stays idle.
- Assert reset asynchronously mid-RUN between clock edges → bus=0xFFFFFFFF immediately, entry_count=0, done=0.
